// File: rtl/seg_disp_arbiter.sv
// Two-requester round-robin arbiter for a six-digit seven-segment display.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits above HEX0.
module seg_disp_arbiter #(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [23:0] data0,
    input  logic [23:0] data1,
    output logic [1:0]  gnt,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN    = 2'd1,
        SWITCH = 2'd2
    } state_t;

    localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;

    state_t      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [31:0] cnt_q, cnt_d;
    logic        ptr_q, ptr_d;
    logic        owner_q, owner_d;
    logic [41:0] hex_q, hex_d;
    logic        other;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    function automatic logic [41:0] decode_word(input logic [23:0] d);
        logic [41:0] w;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        logic        seen;
`endif
        w = '0;
        for (int n = 0; n < 6; n++) begin
            w[n*7 +: 7] = seg7(d[n*4 +: 4]);
        end
`ifdef SEG_LEADING_ZERO_BLANK_EN
        // Walk down from the top digit; HEX0 always shows its digit.
        seen = 1'b0;
        for (int n = 5; n >= 1; n--) begin
            if (d[n*4 +: 4] != 4'h0) begin
                seen = 1'b1;
            end
            if (!seen) begin
                w[n*7 +: 7] = SEG_BLANK;
            end
        end
`endif
        return w;
    endfunction

    assign other = ~owner_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                gnt_d = 2'b00;
                cnt_d = '0;
                if (req == 2'b11) begin
                    owner_d = ptr_q;
                    ptr_d   = ~ptr_q;
                end else if (req[0]) begin
                    owner_d = 1'b0;
                end else if (req[1]) begin
                    owner_d = 1'b1;
                end
                if (req != 2'b00) begin
                    state_d = OWN;
                    gnt_d   = owner_d ? 2'b10 : 2'b01;
                end
            end
            OWN: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    cnt_d   = '0;
                end else if (!req[other]) begin
                    cnt_d = '0;
                end else if (cnt_q >= HOLD_LAST) begin
                    // Break-before-make: one cycle with no grant before handing over.
                    state_d = SWITCH;
                    gnt_d   = 2'b00;
                    cnt_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            SWITCH: begin
                gnt_d = 2'b00;
                cnt_d = '0;
                if (req[other]) begin
                    state_d = OWN;
                    owner_d = other;
                    gnt_d   = other ? 2'b10 : 2'b01;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                cnt_d   = '0;
            end
        endcase
    end

    // Segments follow the owner only while it is still requesting.
    always_comb begin
        hex_d = hex_q;
        if (gnt_q[0] && req[0]) begin
            hex_d = decode_word(data0);
        end else if (gnt_q[1] && req[1]) begin
            hex_d = decode_word(data1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            cnt_q   <= '0;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            hex_q   <= {6{SEG_BLANK}};
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            hex_q   <= hex_d;
        end
    end

    assign gnt  = gnt_q;
    assign HEX0 = hex_q[6:0];
    assign HEX1 = hex_q[13:7];
    assign HEX2 = hex_q[20:14];
    assign HEX3 = hex_q[27:21];
    assign HEX4 = hex_q[34:28];
    assign HEX5 = hex_q[41:35];

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Testbench for seg_disp_arbiter: directed vector table with a scoreboard queue,
// followed by a random phase checking grant exclusivity and bounded waiting.
module tb_seg_disp_arbiter;

    localparam int HOLD = 4;
    localparam int NVEC = 32;
    localparam int NRAND = 10000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [23:0] data0;
    logic [23:0] data1;
    logic [1:0]  gnt;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        rstN;
        logic [1:0]  req;
        logic [23:0] d0;
        logic [23:0] d1;
        logic [1:0]  expGnt;
        logic [1:0]  hexMode;
        logic [23:0] expData;
    } vec_t;

    typedef struct {
        int          row;
        logic [1:0]  gnt;
        logic        checkHex;
        logic [41:0] hex;
    } exp_t;

    localparam logic [1:0] HB = 2'd1;
    localparam logic [1:0] HD = 2'd2;

    vec_t vecs [NVEC];
    exp_t expQ [$];

    logic [6:0] segTab [16];

    seg_disp_arbiter #(.HOLD_CYCLES(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .data0 (data0),
        .data1 (data1),
        .gnt   (gnt),
        .HEX0  (HEX0),
        .HEX1  (HEX1),
        .HEX2  (HEX2),
        .HEX3  (HEX3),
        .HEX4  (HEX4),
        .HEX5  (HEX5)
    );

    always #5 clk = ~clk;

    function automatic logic [41:0] expectHex(input logic [23:0] d);
        logic [41:0] w;
        for (int n = 0; n < 6; n++) begin
            w[n*7 +: 7] = segTab[d[n*4 +: 4]];
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (n > 0 && (d >> (4 * n)) == 24'h0) begin
                w[n*7 +: 7] = 7'b1111111;
            end
`endif
        end
        return w;
    endfunction

    task automatic applyStimulus(input int row, input vec_t v);
        exp_t e;
        rst_n = v.rstN;
        req   = v.req;
        data0 = v.d0;
        data1 = v.d1;
        e.row      = row;
        e.gnt      = v.expGnt;
        e.checkHex = (v.hexMode != 2'd0);
        e.hex      = (v.hexMode == HB) ? {6{7'b1111111}} : expectHex(v.expData);
        expQ.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        logic [41:0] got;
        if (expQ.size() == 0) begin
            failures++;
            checks++;
            $display("[TB] FAIL scoreboard: queue empty, got gnt=%b want an entry", gnt);
            return;
        end
        e = expQ.pop_front();
        got = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
        checks++;
        if (gnt !== e.gnt) begin
            failures++;
            $display("[TB] FAIL row%0d gnt: got %b want %b", e.row, gnt, e.gnt);
        end
        if (e.checkHex) begin
            checks++;
            if (got !== e.hex) begin
                failures++;
                $display("[TB] FAIL row%0d hex: got %h want %h", e.row, got, e.hex);
            end
        end
    endtask

    initial begin
        int waitCnt [2];
        int worstWait;
        segTab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                   7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                   7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

        // {rst_n, req, data0, data1, expected gnt, hex mode, expected data}
        vecs[0]  = '{1'b0, 2'b00, 24'h000000, 24'h000000, 2'b00, HB, 24'h0};
        vecs[1]  = '{1'b0, 2'b11, 24'h000000, 24'h000000, 2'b00, HB, 24'h0};
        vecs[2]  = '{1'b1, 2'b01, 24'h012345, 24'h000000, 2'b01, HB, 24'h0};
        vecs[3]  = '{1'b1, 2'b01, 24'h012345, 24'h000000, 2'b01, HD, 24'h012345};
        vecs[4]  = '{1'b1, 2'b01, 24'hABCDEF, 24'h000000, 2'b01, HD, 24'hABCDEF};
        vecs[5]  = '{1'b1, 2'b00, 24'h987654, 24'h000000, 2'b00, HD, 24'hABCDEF};
        vecs[6]  = '{1'b1, 2'b00, 24'h111111, 24'h000000, 2'b00, HD, 24'hABCDEF};
        vecs[7]  = '{1'b0, 2'b00, 24'h000000, 24'h000000, 2'b00, HB, 24'h0};
        vecs[8]  = '{1'b1, 2'b11, 24'h000000, 24'hFEDCBA, 2'b01, HB, 24'h0};
        vecs[9]  = '{1'b1, 2'b11, 24'h000000, 24'hFEDCBA, 2'b01, HD, 24'h000000};
        vecs[10] = '{1'b1, 2'b11, 24'h000000, 24'hFEDCBA, 2'b01, HD, 24'h000000};
        vecs[11] = '{1'b1, 2'b11, 24'h000000, 24'hFEDCBA, 2'b01, HD, 24'h000000};
        vecs[12] = '{1'b1, 2'b11, 24'h000000, 24'hFEDCBA, 2'b00, HD, 24'h000000};
        vecs[13] = '{1'b1, 2'b11, 24'h000000, 24'hFEDCBA, 2'b10, HD, 24'h000000};
        vecs[14] = '{1'b1, 2'b11, 24'h000000, 24'hFEDCBA, 2'b10, HD, 24'hFEDCBA};
        vecs[15] = '{1'b0, 2'b11, 24'h000000, 24'hFEDCBA, 2'b00, HB, 24'h0};
        vecs[16] = '{1'b1, 2'b00, 24'h000000, 24'h000000, 2'b00, HB, 24'h0};
        vecs[17] = '{1'b1, 2'b10, 24'h000000, 24'h00F00A, 2'b10, HB, 24'h0};
        vecs[18] = '{1'b1, 2'b01, 24'h000123, 24'h00F00A, 2'b00, HB, 24'h0};
        vecs[19] = '{1'b1, 2'b01, 24'h000123, 24'h00F00A, 2'b01, HB, 24'h0};
        for (int i = 20; i <= 24; i++) begin
            vecs[i] = '{1'b1, 2'b01, 24'h000123, 24'h00F00A, 2'b01, HD, 24'h000123};
        end
        vecs[25] = '{1'b1, 2'b11, 24'h000123, 24'h00F00A, 2'b01, HD, 24'h000123};
        vecs[26] = '{1'b1, 2'b11, 24'h000123, 24'h00F00A, 2'b01, HD, 24'h000123};
        vecs[27] = '{1'b1, 2'b11, 24'h000123, 24'h00F00A, 2'b01, HD, 24'h000123};
        vecs[28] = '{1'b1, 2'b11, 24'h000123, 24'h00F00A, 2'b00, HD, 24'h000123};
        vecs[29] = '{1'b1, 2'b01, 24'h000123, 24'h00F00A, 2'b00, HD, 24'h000123};
        vecs[30] = '{1'b1, 2'b01, 24'h000123, 24'h00F00A, 2'b01, HD, 24'h000123};
        vecs[31] = '{1'b1, 2'b01, 24'h00F00A, 24'h00F00A, 2'b01, HD, 24'h00F00A};

        rst_n = 1'b0;
        req   = 2'b00;
        data0 = '0;
        data1 = '0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            applyStimulus(i, vecs[i]);
            @(posedge clk);
            #1;
            checkOutput();
        end

        // Random phase: grant exclusivity every cycle and a bound on how long
        // a requester waits while the other keeps requesting.
        waitCnt[0] = 0;
        waitCnt[1] = 0;
        worstWait  = 0;
        for (int c = 0; c < NRAND; c++) begin
            @(negedge clk);
            rst_n = 1'b1;
            if ($urandom_range(7) == 0) req[0] = ~req[0];
            if ($urandom_range(7) == 0) req[1] = ~req[1];
            data0 = 24'($urandom);
            data1 = 24'($urandom);
            checks++;
            if (gnt === 2'b11 || $isunknown(gnt)) begin
                failures++;
                $display("[TB] FAIL rand%0d onehot: got gnt=%b want at most one bit", c, gnt);
            end
            for (int k = 0; k < 2; k++) begin
                if (!req[k] || gnt[k] || !req[1-k]) begin
                    waitCnt[k] = 0;
                end else begin
                    waitCnt[k]++;
                end
                if (waitCnt[k] > worstWait) worstWait = waitCnt[k];
                checks++;
                if (waitCnt[k] > HOLD + 2) begin
                    failures++;
                    $display("[TB] FAIL rand%0d wait%0d: got %0d cycles want <= %0d",
                             c, k, waitCnt[k], HOLD + 2);
                end
            end
        end
        $display("[TB] random phase longest wait %0d cycles", worstWait);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
